pc_fetch_ctrl_rv32i: RTL and testbench
======================================

// Module: pc_fetch_ctrl_rv32i
// PURPOSE
// - Program-counter and fetch-control stage that sits directly upstream of the RV32I instruction ROM.
// - Holds the architectural PC and drives it onto the ROM byte address.
// - Selects the next PC from: sequential (+4), branch target, jump target, or hold.
// - Runs a small boot/run/halt/fault FSM and counts retired instructions.
// PARAMETERS
// - RESET_VEC   32'h0000_0000  PC value loaded on reset.
// - IMEM_WORDS  32             Instruction memory depth in words; the legal byte range is [0, IMEM_WORDS*4).
// - EBREAK_HALT 1              1 = an EBREAK fetch halts the core; 0 = EBREAK is treated as a normal instruction.
// PORTS
// - clock          in   1   System clock; the PC updates on the rising edge.
// - reset_n        in   1   Asynchronous, active-low reset.
// - stall          in   1   Hold the PC this cycle; the instruction does not retire.
// - branch_taken   in   1   Conditional branch resolved taken this cycle.
// - branch_target  in   32  Byte address for a taken branch.
// - jump           in   1   JAL/JALR this cycle.
// - jump_target    in   32  Byte address for the jump; the JALR bit 0 is already cleared by the producer.
// - instr          in   32  Instruction word returned by the ROM for the current PC.
// - PC             out  32  Current byte address to the ROM.
// - pc_plus4       out  32  PC+4, used for the rd write of JAL/JALR.
// - fetch_valid    out  1   instr is a real instruction to execute this cycle.
// - halted         out  1   Core stopped on EBREAK.
// - fault          out  1   Redirect target was misaligned or out of range.
// - fault_addr     out  32  The offending target address, captured on fault entry.
// - instret        out  32  Retired-instruction counter.
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - state=BOOT, PC=RESET_VEC, instret=0, fault_addr=0.
//   - fetch_valid=0, halted=0, fault=0.
// - pc_plus4 = PC + 32'd4, combinational; wraps modulo 2^32.
// - The ROM samples PC on the falling edge, so instr is valid from mid-cycle onward.
// - All decisions use instr, redirect inputs and stall, sampled at the rising edge.
// - FSM states:
//   - BOOT: fetch_valid=0 and PC is held. Unconditionally goes to RUN at the next edge (one dead cycle so the ROM output settles).
//   - RUN: fetch_valid=1. At each rising edge, the first matching rule applies:
//     - 1. stall=1: PC held, instret held, state stays RUN; redirect inputs are ignored.
//     - 2. EBREAK_HALT && instr==32'h0010_0073: go to HALT. PC held at the EBREAK address; instret not incremented.
//     - 3. jump=1: take jump_target. jump beats branch_taken when both are asserted.
//     - 4. branch_taken=1: take branch_target.
//     - 5. Otherwise: take pc_plus4.
//     - For rules 3-5, if the selected next PC has bits[1:0]!=0 or is >= IMEM_WORDS*4:
//       - go to FAULT, PC held, fault_addr = the bad target, instret NOT incremented.
//     - Otherwise: PC = next PC and instret = instret+1 (wraps at 2^32).
//     - Sequential fall-off past the last word (PC+4 == IMEM_WORDS*4) is a fault.
//   - HALT: halted=1, fetch_valid=0, PC and instret frozen. Exit only by reset.
//   - FAULT: fault=1, fetch_valid=0, PC, fault_addr and instret frozen. Exit only by reset.
// - Outputs are registered or decoded from the state only; no combinational path from inputs to fetch_valid, halted or fault.
// - Reset asserted mid-operation, in any state, returns everything to reset values immediately (asynchronously).
// - After reset release, the first fetch_valid=1 cycle is the second rising edge.
// TESTING
// - Release reset; instr=NOP (32'h0000_0013) throughout.
//   -> cycle 0: fetch_valid=0, PC=0.
//   -> then PC=0,4,8,12 with instret=0,1,2,3.
// - At PC=8, assert jump=1, jump_target=0x40 and branch_taken=1, branch_target=0x10.
//   -> next PC=0x40 (jump wins); instret increments once.
// - At PC=0x10, assert stall=1 for 3 cycles together with branch_taken=1, target 0x20.
//   -> PC stays 0x10 and instret is frozen for 3 cycles.
//   -> the branch is then taken only if it is still asserted after the stall drops.
// - At PC=0x0C, assert branch_taken=1, target 0x16.
//   -> fault=1, fault_addr=0x16, PC=0x0C held, fetch_valid=0.
//   -> a second test uses target 0x80 (IMEM_WORDS=32) -> same fault response.
// - At PC=0x14, present instr=0x0010_0073.
//   -> halted=1, PC=0x14, instret unchanged, and all later redirects are ignored.
// - Pulse reset_n low between rising edges while in HALT or FAULT.
//   -> outputs clear immediately (not on the next edge).
//   -> BOOT then RUN resumes from RESET_VEC.
// - Run with PC approaching 0x7C.
//   -> sequential step to 0x80 faults with fault_addr=0x80.

Source files
------------

// File: rtl/pc_fetch_ctrl_rv32i.sv
// RV32I program counter and fetch control ahead of the instruction ROM.
// Boot/run/halt/fault sequencing, next-PC selection and retire counting.
module pc_fetch_ctrl_rv32i #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter int          IMEM_WORDS  = 32,
  parameter bit          EBREAK_HALT = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instr,
  output logic [31:0] PC,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT,
    FAULT
  } state_t;

  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_t      state;
  logic [31:0] next_pc;
  logic        bad;
  logic        ebreak;

  assign pc_plus4 = PC + 32'd4;
  assign ebreak   = EBREAK_HALT && (instr == EBREAK);

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = jump_target;
    else if (branch_taken)
      next_pc = branch_target;
  end

  assign bad = (next_pc[1:0] != 2'b00) || (next_pc >= LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      PC          <= RESET_VEC;
      instret     <= 32'd0;
      fault_addr  <= 32'd0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (stall) begin
            state <= RUN;
          end else if (ebreak) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end else if (bad) begin
            state       <= FAULT;
            fetch_valid <= 1'b0;
            fault       <= 1'b1;
            fault_addr  <= next_pc;
          end else begin
            PC      <= next_pc;
            instret <= instret + 32'd1;
          end
        end
        HALT: state <= HALT;
        FAULT: state <= FAULT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl_rv32i.sv
// Directed bench for pc_fetch_ctrl_rv32i.
// Linear steps with hand-computed expectations.
module tb_pc_fetch_ctrl_rv32i;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBK = 32'h0010_0073;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr;
  logic [31:0] PC;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] instret;

  int checks;
  int failures;

  pc_fetch_ctrl_rv32i dut (
    .clock(clock),
    .reset_n(reset_n),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .instr(instr),
    .PC(PC),
    .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid),
    .halted(halted),
    .fault(fault),
    .fault_addr(fault_addr),
    .instret(instret)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    jump          = 1'b0;
    jump_target   = 32'd0;
    instr         = NOP;
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "_pc"}, PC, 32'd0);
    chk({tag, "_fv"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, "_halt"}, {31'd0, halted}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_faddr"}, fault_addr, 32'd0);
    chk({tag, "_iret"}, instret, 32'd0);
    #1 reset_n = 1'b1;
    clr();
    tick();
    chk({tag, "_boot_fv"}, {31'd0, fetch_valid}, 32'd1);
    chk({tag, "_boot_pc"}, PC, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    clr();
    #12;
    chk("rst_pc", PC, 32'd0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst_iret", instret, 32'd0);
    chk("rst_halt", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);
    chk("rst_p4", pc_plus4, 32'd4);
    reset_n = 1'b1;

    tick();
    chk("boot_fv", {31'd0, fetch_valid}, 32'd1);
    chk("boot_pc", PC, 32'd0);
    chk("boot_iret", instret, 32'd0);
    tick();
    chk("seq_pc4", PC, 32'd4);
    chk("seq_ir1", instret, 32'd1);
    tick();
    chk("seq_pc8", PC, 32'd8);
    chk("seq_ir2", instret, 32'd2);

    jump = 1'b1; jump_target = 32'h40;
    branch_taken = 1'b1; branch_target = 32'h10;
    tick();
    chk("jmp_win_pc", PC, 32'h40);
    chk("jmp_win_ir", instret, 32'd3);
    clr();

    branch_taken = 1'b1; branch_target = 32'h10;
    tick();
    chk("br_pc", PC, 32'h10);
    chk("br_ir", instret, 32'd4);

    stall = 1'b1; branch_target = 32'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", PC, 32'h10);
      chk("stall_ir", instret, 32'd4);
    end
    stall = 1'b0;
    tick();
    chk("post_stall_pc", PC, 32'h20);
    chk("post_stall_ir", instret, 32'd5);
    clr();
    tick();
    chk("seq_pc24", PC, 32'h24);
    chk("seq_ir6", instret, 32'd6);

    jump = 1'b1; jump_target = 32'h0C;
    tick();
    chk("jmp_c_pc", PC, 32'h0C);
    clr();
    branch_taken = 1'b1; branch_target = 32'h16;
    tick();
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_faddr", fault_addr, 32'h16);
    chk("mis_pc", PC, 32'h0C);
    chk("mis_fv", {31'd0, fetch_valid}, 32'd0);
    chk("mis_ir", instret, 32'd7);
    branch_target = 32'h30;
    jump = 1'b1; jump_target = 32'h40;
    tick();
    chk("mis_frz_pc", PC, 32'h0C);
    chk("mis_frz_fa", fault_addr, 32'h16);
    chk("mis_frz_ir", instret, 32'd7);

    pulse_reset("rst_flt");

    jump = 1'b1; jump_target = 32'h0C;
    tick();
    chk("jmp_c2_pc", PC, 32'h0C);
    chk("jmp_c2_ir", instret, 32'd1);
    clr();
    branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    chk("oor_fault", {31'd0, fault}, 32'd1);
    chk("oor_faddr", fault_addr, 32'h80);
    chk("oor_pc", PC, 32'h0C);
    chk("oor_fv", {31'd0, fetch_valid}, 32'd0);

    pulse_reset("rst_oor");

    jump = 1'b1; jump_target = 32'h14;
    tick();
    chk("jmp_14_pc", PC, 32'h14);
    clr();
    instr = EBK;
    tick();
    chk("ebk_halt", {31'd0, halted}, 32'd1);
    chk("ebk_pc", PC, 32'h14);
    chk("ebk_ir", instret, 32'd1);
    chk("ebk_fv", {31'd0, fetch_valid}, 32'd0);
    chk("ebk_fault", {31'd0, fault}, 32'd0);
    instr = NOP;
    jump = 1'b1; jump_target = 32'h40;
    tick();
    chk("halt_frz_pc", PC, 32'h14);
    chk("halt_frz_ir", instret, 32'd1);
    chk("halt_frz_h", {31'd0, halted}, 32'd1);

    pulse_reset("rst_halt");

    jump = 1'b1; jump_target = 32'h78;
    tick();
    chk("jmp_78_pc", PC, 32'h78);
    chk("jmp_78_p4", pc_plus4, 32'h7C);
    clr();
    tick();
    chk("seq_7c_pc", PC, 32'h7C);
    chk("seq_7c_p4", pc_plus4, 32'h80);
    chk("seq_7c_ir", instret, 32'd2);
    tick();
    chk("fall_fault", {31'd0, fault}, 32'd1);
    chk("fall_faddr", fault_addr, 32'h80);
    chk("fall_pc", PC, 32'h7C);
    chk("fall_ir", instret, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
